fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core; the producing end of the opcode/instr interface consumed by the decode-stage control logic.

---
 rtl/core_pkg.sv | 32 +++
 rtl/if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: reset PC, bubble encoding,
// opcode constants and the IF/ID update-priority helper.
package core_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0000;

    // Opcodes consumed by the decode-stage control logic.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // What the IF/ID register does on a non-reset edge.
    typedef enum logic [1:0] {
        ID_BUBBLE,
        ID_HOLD,
        ID_LOAD
    } id_action_e;

    // Flush beats stall; otherwise the register loads.
    function automatic id_action_e id_action(input logic flush, input logic stall);
        if (flush) return ID_BUBBLE;
        if (stall) return ID_HOLD;
        return ID_LOAD;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC, PC+4 and valid flag with
// reset > flush > stall > load priority.
module if_id_reg
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] fetch_instr,
    input  logic [ADDR_WIDTH-1:0]  fetch_pc,
    input  logic [ADDR_WIDTH-1:0]  fetch_pc_plus4,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  pc_plus4,
    output logic                   valid
);

    // Capture, squash or hold the Decode-stage instruction slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= INSTR_WIDTH'(NOP_BUBBLE);
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else begin
            case (id_action(flush, stall))
                ID_BUBBLE: begin
                    instr    <= INSTR_WIDTH'(NOP_BUBBLE);
                    pc       <= '0;
                    pc_plus4 <= '0;
                    valid    <= 1'b0;
                end
                ID_LOAD: begin
                    instr    <= fetch_instr;
                    pc       <= fetch_pc;
                    pc_plus4 <= fetch_pc_plus4;
                    valid    <= 1'b1;
                end
                // NOTE: leaving a flop unassigned inside always_ff is a clean hold (enable), not a latch.
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, shared +4 adder, redirect/stall
// PC mux, IF/ID register and a count of instructions entering Decode.
module fetch_stage
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    OP_WIDTH    = 7,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   StallF,
    input  logic                   StallD,
    input  logic                   FlushD,
    input  logic                   PCSrcE,
    input  logic [ADDR_WIDTH-1:0]  PCTargetE,
    input  logic [INSTR_WIDTH-1:0] InstrF,
    output logic [ADDR_WIDTH-1:0]  PCF,
    output logic [INSTR_WIDTH-1:0] InstrD,
    output logic [OP_WIDTH-1:0]    OpD,
    output logic [ADDR_WIDTH-1:0]  PCD,
    output logic [ADDR_WIDTH-1:0]  PCPlus4D,
    output logic                   ValidD,
    output logic [31:0]            FetchCnt
);

    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  squash_d;

    // One adder feeds both the sequential PC path and the link value.
    assign pc_plus4 = PCF + ADDR_WIDTH'(4);

    // A redirect kills whatever was fetched this cycle.
    assign squash_d = FlushD | PCSrcE;

    // Next-PC select: redirect (word-aligned) > stall > sequential.
    always_comb begin
        pc_next = pc_plus4;
        if (PCSrcE)
            pc_next = PCTargetE & ~ADDR_WIDTH'(3);
        else if (StallF)
            pc_next = PCF;
    end

    // PC register; PCF is driven straight from the flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst)
            PCF <= RESET_PC;
        else
            PCF <= pc_next;
    end

    // Count edges on which a real instruction is loaded into Decode.
    always_ff @(posedge clk) begin
        if (rst)
            FetchCnt <= '0;
        else if (id_action(squash_d, StallD) == ID_LOAD)
            FetchCnt <= FetchCnt + 32'd1;
    end

    if_id_reg #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_if_id (
        .clk            (clk),
        .rst            (rst),
        .stall          (StallD),
        .flush          (squash_d),
        .fetch_instr    (InstrF),
        .fetch_pc       (PCF),
        .fetch_pc_plus4 (pc_plus4),
        .instr          (InstrD),
        .pc             (PCD),
        .pc_plus4       (PCPlus4D),
        .valid          (ValidD)
    );

    assign OpD = InstrD[OP_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// random control traffic, compared against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCnt;
    logic [6:0]  OpD;
    logic        ValidD;

    logic [31:0] imem [256];

    int errors = 0;
    int checks = 0;

    // Behavioural model of the architecturally visible state.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
    logic        m_valid;

    always #5 clk = ~clk;

    // Instruction memory read combinationally at PCF.
    assign InstrF = imem[PCF[9:2]];

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .OpD       (OpD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .FetchCnt  (FetchCnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the documented rules,
    // clock the DUT and compare every output.
    task automatic step(input logic r, input logic sf, input logic sd,
                        input logic fd, input logic ps, input logic [31:0] tgt);
        logic [31:0] fetched;
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        fetched = imem[m_pc[9:2]];
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_cnt = 32'h0;
        end else begin
            if (fd || ps) begin
                m_instr = 32'h0; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!sd) begin
                m_instr = fetched; m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            if (ps)       m_pc = (tgt / 4) * 4;
            else if (!sf) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check("PCF",      PCF,            m_pc);
        check("InstrD",   InstrD,         m_instr);
        check("OpD",      {25'b0, OpD},   {25'b0, m_instr[6:0]});
        check("PCD",      PCD,            m_pcd);
        check("PCPlus4D", PCPlus4D,       m_pc4);
        check("ValidD",   {31'b0, ValidD}, {31'b0, m_valid});
        check("FetchCnt", FetchCnt,       m_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] cnt_snap;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        m_pc = '0; m_instr = '0; m_pcd = '0; m_pc4 = '0; m_cnt = '0; m_valid = 1'b0;

        // T1 reset and release
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("T1 rst PCF",      PCF,      32'h0);
        check("T1 rst ValidD",   {31'b0, ValidD}, 32'h0);
        check("T1 rst OpD",      {25'b0, OpD}, 32'h0);
        check("T1 rst FetchCnt", FetchCnt, 32'h0);
        run(1);
        check("T1 PCF 4",        PCF,      32'h4);
        check("T1 InstrD",       InstrD,   imem[0]);
        check("T1 PCD",          PCD,      32'h0);
        check("T1 PCPlus4D",     PCPlus4D, 32'h4);
        check("T1 ValidD",       {31'b0, ValidD}, 32'h1);
        run(1);
        check("T1 PCF 8",        PCF,      32'h8);

        // T2 stall at PCF=0x10
        run(2);
        check("T2 PCF pre",      PCF,      32'h10);
        cnt_snap = FetchCnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check("T2 PCF hold",   PCF,    32'h10);
            check("T2 PCD hold",   PCD,    32'hC);
            check("T2 InstrD hold", InstrD, imem[3]);
            check("T2 cnt hold",   FetchCnt, cnt_snap);
        end
        run(1);
        check("T2 PCF release",  PCF,      32'h14);

        // T3 redirect at PCF=0x20
        run(3);
        check("T3 PCF pre",      PCF,      32'h20);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
        check("T3 PCF target",   PCF,      32'h40);
        check("T3 bubble",       {31'b0, ValidD}, 32'h0);
        run(1);
        check("T3 InstrD",       InstrD,   imem[16]);
        check("T3 PCD",          PCD,      32'h40);
        check("T3 ValidD",       {31'b0, ValidD}, 32'h1);

        // T4 redirect beats stall, target aligned down
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h43);
        check("T4 PCF",          PCF,      32'h40);
        check("T4 ValidD",       {31'b0, ValidD}, 32'h0);
        check("T4 InstrD",       InstrD,   32'h0);

        // T5 flush beats stall
        run(1);
        cnt_snap = FetchCnt;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("T5 InstrD",       InstrD,   32'h0);
        check("T5 OpD",          {25'b0, OpD}, 32'h0);
        check("T5 ValidD",       {31'b0, ValidD}, 32'h0);
        check("T5 FetchCnt",     FetchCnt, cnt_snap);

        // StallF without StallD: duplicate load of the same PC
        run(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("dup PCD",         PCD,      m_pcd);

        // T6 wrap and mid-run reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("T6 PCF top",      PCF,      32'hFFFF_FFFC);
        run(1);
        check("T6 PCF wrap",     PCF,      32'h0);
        check("T6 PCD",          PCD,      32'hFFFF_FFFC);
        check("T6 PCPlus4D",     PCPlus4D, 32'h0);
        run(3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("T6 rst PCF",      PCF,      32'h0);
        check("T6 rst ValidD",   {31'b0, ValidD}, 32'h0);
        check("T6 rst InstrD",   InstrD,   32'h0);
        check("T6 rst FetchCnt", FetchCnt, 32'h0);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
